dmem_responder: RTL and testbench

Multi-cycle data-memory responder: the slave end of the CPU's data-memory port. It accepts one load/store request at a time over a valid/ready handshake, waits a fixed access latency, and then presents the response, holding it until the requester takes it. Stores commit with per-byte strobes. Misaligned or out-of-range accesses return an error response. It replaces the zero-latency DataMemory behind a CPU core that stalls on the handshake.

---
 rtl/dmem_pkg.sv | 20 ++
 rtl/dmem_storage.sv | 35 +++
 rtl/dmem_responder.sv | 153 +++++++++++++++
 tb/tb_dmem_responder.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types, constants and access checking for the data-memory responder.
package dmem_pkg;

    localparam int unsigned WORD_BYTES = 4;
    localparam int unsigned STRB_W     = 4;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    // An access is rejected when it is not word aligned or its word index is out of range.
    function automatic logic access_err(input logic [31:0] addr, input int unsigned depth_words);
        logic [31:0] word_idx;
        word_idx   = {2'b00, addr[31:2]};
        access_err = (addr[1:0] != 2'b00) || (word_idx >= depth_words);
    endfunction

endpackage

// File: rtl/dmem_storage.sv
// Byte-lane word array: synchronous clear, strobed writes, combinational read.
module dmem_storage
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 16384,
    parameter int unsigned IDX_W       = 14
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [IDX_W-1:0]  idx_i,
    input  logic [31:0]       wdata_i,
    input  logic [STRB_W-1:0] wstrb_i,
    input  logic              we_i,
    output logic [31:0]       rdata_o
);

    logic [31:0] mem_q [DEPTH_WORDS];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int unsigned w = 0; w < DEPTH_WORDS; w++) begin
                mem_q[w] <= '0;
            end
        end else if (we_i) begin
            for (int unsigned i = 0; i < STRB_W; i++) begin
                if (wstrb_i[i]) begin
                    mem_q[idx_i][8*i +: 8] <= wdata_i[8*i +: 8];
                end
            end
        end
    end

    assign rdata_o = mem_q[idx_i];

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory slave: valid/ready request, fixed latency, held response.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 16384,
    parameter int unsigned LATENCY     = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    input  logic [STRB_W-1:0] req_wstrb,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic              busy
);

    localparam int unsigned CNT_W = $clog2(LATENCY + 1);
    localparam int unsigned IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic                write_q, write_d;
    logic [31:0]         addr_q, addr_d;
    logic [31:0]         wdata_q, wdata_d;
    logic [STRB_W-1:0]   wstrb_q, wstrb_d;
    logic [31:0]         rdata_q, rdata_d;
    logic                err_q, err_d;

    logic                acc_write;
    logic [31:0]         acc_addr;
    logic [31:0]         acc_wdata;
    logic [STRB_W-1:0]   acc_wstrb;
    logic                acc_err;
    logic                go_resp;
    logic                mem_we;
    logic [31:0]         mem_rdata;

    // With LATENCY=1 the access edge is the acceptance edge, so the live request is used.
    always_comb begin
        if (state_q == IDLE) begin
            acc_write = req_write;
            acc_addr  = req_addr;
            acc_wdata = req_wdata;
            acc_wstrb = req_wstrb;
        end else begin
            acc_write = write_q;
            acc_addr  = addr_q;
            acc_wdata = wdata_q;
            acc_wstrb = wstrb_q;
        end
        acc_err = access_err(acc_addr, DEPTH_WORDS);
    end

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        write_d    = write_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        rdata_d    = rdata_q;
        err_d      = err_q;
        go_resp    = 1'b0;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        busy       = 1'b1;

        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                busy      = 1'b0;
                if (req_valid) begin
                    write_d = req_write;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    wstrb_d = req_wstrb;
                    if (LATENCY == 1) begin
                        go_resp = 1'b1;
                        state_d = RESP;
                    end else begin
                        count_d = CNT_W'(LATENCY - 1);
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                count_d = count_q - CNT_W'(1);
                if (count_q == CNT_W'(1)) begin
                    go_resp = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (go_resp) begin
            err_d   = acc_err;
            rdata_d = (!acc_write && !acc_err) ? mem_rdata : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            count_q <= '0;
            write_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            write_q <= write_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    assign mem_we     = go_resp && acc_write && !acc_err && !reset;
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;

    dmem_storage #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .IDX_W       (IDX_W)
    ) u_storage (
        .clk_i   (clk),
        .rst_i   (reset),
        .idx_i   (acc_addr[IDX_W+1:2]),
        .wdata_i (acc_wdata),
        .wstrb_i (acc_wstrb),
        .we_i    (mem_we),
        .rdata_o (mem_rdata)
    );

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: default build plus a LATENCY=1 build.
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        reset;

    logic        req_valid, req_ready, req_write;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_wstrb;
    logic        resp_valid, resp_ready, resp_err, busy;
    logic [31:0] resp_rdata;

    logic        req_valid1, req_ready1, req_write1;
    logic [31:0] req_addr1, req_wdata1;
    logic [3:0]  req_wstrb1;
    logic        resp_valid1, resp_ready1, resp_err1, busy1;
    logic [31:0] resp_rdata1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dmem_responder dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_wstrb  (req_wstrb),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .busy       (busy)
    );

    dmem_responder #(
        .DEPTH_WORDS (16),
        .LATENCY     (1)
    ) dut1 (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid1),
        .req_ready  (req_ready1),
        .req_write  (req_write1),
        .req_addr   (req_addr1),
        .req_wdata  (req_wdata1),
        .req_wstrb  (req_wstrb1),
        .resp_valid (resp_valid1),
        .resp_ready (resp_ready1),
        .resp_rdata (resp_rdata1),
        .resp_err   (resp_err1),
        .busy       (busy1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One request on the default build with resp_ready high; returns data, error and latency.
    task automatic run_req(input logic w, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s, output logic [31:0] rd, output logic e,
                           output int lat);
        req_write  = w;
        req_addr   = a;
        req_wdata  = d;
        req_wstrb  = s;
        req_valid  = 1'b1;
        resp_ready = 1'b1;
        tick();
        req_valid = 1'b0;
        lat = 1;
        while (!resp_valid && lat < 50) begin
            tick();
            lat++;
        end
        rd = resp_rdata;
        e  = resp_err;
        tick();
        chk("post_hs_resp_valid", resp_valid, 0);
        chk("post_hs_req_ready", req_ready, 1);
    endtask

    logic [31:0] rd;
    logic        e;
    int          lat;
    int          n;
    int          accepts;

    initial begin
        reset = 1'b1;
        req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
        resp_ready = 1'b0;
        req_valid1 = 1'b0; req_write1 = 1'b0; req_addr1 = '0; req_wdata1 = '0; req_wstrb1 = '0;
        resp_ready1 = 1'b0;
        tick();
        tick();
        reset = 1'b0;

        chk("rst_req_ready", req_ready, 1);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_resp_rdata", resp_rdata, 0);
        chk("rst_resp_err", resp_err, 0);
        chk("rst_busy", busy, 0);

        run_req(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, rd, e, lat);
        chk("st_latency", lat, 4);
        chk("st_err", e, 0);
        chk("st_rdata", rd, 0);

        run_req(1'b0, 32'h10, 32'h0, 4'h0, rd, e, lat);
        chk("ld_latency", lat, 4);
        chk("ld_rdata", rd, 32'hDEADBEEF);
        chk("ld_err", e, 0);

        run_req(1'b1, 32'h10, 32'h11223344, 4'b0101, rd, e, lat);
        run_req(1'b0, 32'h10, 32'h0, 4'h0, rd, e, lat);
        chk("strb_rdata", rd, 32'hDE22BE44);

        run_req(1'b0, 32'h12, 32'h0, 4'h0, rd, e, lat);
        chk("misal_err", e, 1);
        chk("misal_rdata", rd, 0);

        run_req(1'b1, 32'h10000, 32'hFFFFFFFF, 4'hF, rd, e, lat);
        chk("oor_err", e, 1);
        chk("oor_rdata", rd, 0);
        run_req(1'b0, 32'h0, 32'h0, 4'h0, rd, e, lat);
        chk("oor_word0", rd, 0);
        chk("oor_word0_err", e, 0);

        run_req(1'b1, 32'h10, 32'h55555555, 4'h0, rd, e, lat);
        chk("nostrb_err", e, 0);
        run_req(1'b0, 32'h10, 32'h0, 4'h0, rd, e, lat);
        chk("nostrb_rdata", rd, 32'hDE22BE44);

        // Backpressure: response held for 7 cycles, stray request ignored.
        req_write = 1'b0; req_addr = 32'h10; req_valid = 1'b1; resp_ready = 1'b0;
        tick();
        req_valid = 1'b0;
        n = 1;
        while (!resp_valid && n < 50) begin
            tick();
            n++;
        end
        chk("bp_latency", n, 4);
        for (int i = 0; i < 7; i++) begin
            chk("bp_resp_valid", resp_valid, 1);
            chk("bp_rdata", resp_rdata, 32'hDE22BE44);
            chk("bp_req_ready", req_ready, 0);
            if (i == 3) begin
                req_write = 1'b1; req_addr = 32'h20; req_wdata = 32'hA5A5A5A5;
                req_wstrb = 4'hF; req_valid = 1'b1;
            end else begin
                req_valid = 1'b0;
            end
            tick();
        end
        req_valid = 1'b0;
        resp_ready = 1'b1;
        tick();
        chk("bp_rel_resp_valid", resp_valid, 0);
        chk("bp_rel_req_ready", req_ready, 1);
        run_req(1'b0, 32'h20, 32'h0, 4'h0, rd, e, lat);
        chk("bp_ignored_store", rd, 0);

        // Reset sampled on the store's access edge.
        req_write = 1'b1; req_addr = 32'h30; req_wdata = 32'hAABBCCDD;
        req_wstrb = 4'hF; req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mrst_req_ready", req_ready, 1);
        chk("mrst_resp_valid", resp_valid, 0);
        chk("mrst_resp_rdata", resp_rdata, 0);
        chk("mrst_resp_err", resp_err, 0);
        chk("mrst_busy", busy, 0);
        run_req(1'b0, 32'h30, 32'h0, 4'h0, rd, e, lat);
        chk("mrst_load", rd, 0);

        // LATENCY=1 build.
        resp_ready1 = 1'b1;
        req_write1 = 1'b1; req_addr1 = 32'h8; req_wdata1 = 32'hCAFEF00D;
        req_wstrb1 = 4'hF; req_valid1 = 1'b1;
        tick();
        req_valid1 = 1'b0;
        chk("l1_st_valid", resp_valid1, 1);
        chk("l1_st_rdata", resp_rdata1, 0);
        tick();
        req_write1 = 1'b0; req_addr1 = 32'h8; req_valid1 = 1'b1;
        tick();
        req_valid1 = 1'b0;
        chk("l1_ld_valid", resp_valid1, 1);
        chk("l1_ld_rdata", resp_rdata1, 32'hCAFEF00D);
        chk("l1_ld_err", resp_err1, 0);
        tick();
        req_addr1 = 32'h40; req_valid1 = 1'b1;
        tick();
        req_valid1 = 1'b0;
        chk("l1_oor_err", resp_err1, 1);
        tick();
        chk("l1_idle_ready", req_ready1, 1);

        req_write1 = 1'b0; req_addr1 = 32'h8; req_valid1 = 1'b1;
        accepts = 0;
        for (int i = 0; i < 8; i++) begin
            if (req_ready1 && req_valid1) accepts++;
            tick();
        end
        req_valid1 = 1'b0;
        chk("l1_b2b_accepts", accepts, 4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
